// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/flush controller: stage indices,
// controller state encoding and the register-hazard helper.
package pipe_ctrl_pkg;

    localparam int unsigned NSTAGE = 5;

    localparam int unsigned STG_IF  = 0;
    localparam int unsigned STG_ID  = 1;
    localparam int unsigned STG_EX  = 2;
    localparam int unsigned STG_MEM = 3;
    localparam int unsigned STG_WB  = 4;

    typedef enum logic [0:0] {
        StIdle,
        StRedirect
    } ctrl_state_e;

    // r0 is hard-wired to zero, so it can never be a producer.
    function automatic logic src_hit(input logic [4:0] rs, input logic rs_use,
                                     input logic [4:0] rd);
        return rs_use && (rd != 5'd0) && (rs == rd);
    endfunction

endpackage

// File: rtl/div_stall_cnt.sv
// Multi-cycle divide occupancy counter: holds EX for DIV_CYCLES cycles from entry,
// then keeps the finished divide parked until MEM can take it.
module div_stall_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic handoff_i,
    input  logic clear_i,
    output logic stall_o
);

    localparam int unsigned CntW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(DIV_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        stall_o = 1'b0;
        if (cnt_q == '0) begin
            if (start_i && (DIV_CYCLES > 1)) begin
                stall_o = 1'b1;
                cnt_d   = CntLoad;
            end
        end else if (cnt_q > CntOne) begin
            stall_o = 1'b1;
            cnt_d   = cnt_q - CntOne;
        end else if (handoff_i) begin
            cnt_d = '0;
        end
        if (clear_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central hazard/flush controller for the five-stage pipeline: load-use interlock,
// divide stall, branch-mispredict flush and exception/ertn redirect.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 4
) (
    input  logic              aclk,
    input  logic              reset,
    input  logic [NSTAGE-1:0] stage_valid,
    input  logic              mem_allow_out,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_rs1_use,
    input  logic              id_rs2_use,
    input  logic [4:0]        ex_rd,
    input  logic              ex_wen,
    input  logic              ex_is_load,
    input  logic              ex_is_div,
    input  logic [4:0]        mem_rd,
    input  logic              mem_load_pending,
    input  logic              ex_br_mispredict,
    input  logic [31:0]       ex_br_target,
    input  logic              wb_excp,
    input  logic [31:0]       wb_excp_target,
    input  logic              redirect_ack,
    output logic [NSTAGE-1:0] ready_go,
    output logic [NSTAGE-1:0] flush,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc
);

    ctrl_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d;

    logic excp, div_stall, ex_ready, br_take;
    logic ex_hit, mem_hit, load_use;
    logic unused_stage_valid_if;

    // IF validity does not influence any hazard decision.
    assign unused_stage_valid_if = stage_valid[STG_IF];

    assign excp     = stage_valid[STG_WB] & wb_excp;
    assign ex_ready = ~div_stall;
    assign br_take  = stage_valid[STG_EX] & ex_br_mispredict & ex_ready & ~excp;

    div_stall_cnt #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_stall_cnt (
        .clk_i     (aclk),
        .rst_i     (reset),
        .start_i   (stage_valid[STG_EX] & ex_is_div),
        .handoff_i (mem_allow_out),
        .clear_i   (excp),
        .stall_o   (div_stall)
    );

    always_comb begin
        ex_hit   = stage_valid[STG_EX] & ex_is_load & ex_wen &
                   (src_hit(id_rs1, id_rs1_use, ex_rd) | src_hit(id_rs2, id_rs2_use, ex_rd));
        mem_hit  = stage_valid[STG_MEM] & mem_load_pending &
                   (src_hit(id_rs1, id_rs1_use, mem_rd) | src_hit(id_rs2, id_rs2_use, mem_rd));
        load_use = stage_valid[STG_ID] & (ex_hit | mem_hit);
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        flush            = '0;
        ready_go         = '1;
        ready_go[STG_EX] = ex_ready;
        ready_go[STG_ID] = ~load_use;

        unique case (state_q)
            StIdle: ;
            StRedirect: begin
                ready_go[STG_IF] = 1'b0;
                if (redirect_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A new redirect source overrides an ack in the same cycle.
        if (excp) begin
            flush   = '1;
            state_d = StRedirect;
            pc_d    = wb_excp_target;
        end else if (br_take) begin
            flush[STG_IF] = 1'b1;
            flush[STG_ID] = 1'b1;
            state_d       = StRedirect;
            pc_d          = ex_br_target;
        end
    end

    assign redirect_valid = (state_q == StRedirect);
    assign redirect_pc    = pc_q;

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized stimulus
// checked against a cycle-level behavioural model of the hazard rules.
module tb_pipe_ctrl;

    localparam int unsigned DivCycles = 4;

    logic        aclk = 1'b0;
    logic        reset;
    logic [4:0]  stage_valid;
    logic        mem_allow_out;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_rs1_use, id_rs2_use;
    logic [4:0]  ex_rd;
    logic        ex_wen, ex_is_load, ex_is_div;
    logic [4:0]  mem_rd;
    logic        mem_load_pending;
    logic        ex_br_mispredict;
    logic [31:0] ex_br_target;
    logic        wb_excp;
    logic [31:0] wb_excp_target;
    logic        redirect_ack;
    logic [4:0]  ready_go, flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 aclk = ~aclk;

    pipe_ctrl #(
        .DIV_CYCLES (DivCycles)
    ) dut (
        .aclk             (aclk),
        .reset            (reset),
        .stage_valid      (stage_valid),
        .mem_allow_out    (mem_allow_out),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_rs1_use       (id_rs1_use),
        .id_rs2_use       (id_rs2_use),
        .ex_rd            (ex_rd),
        .ex_wen           (ex_wen),
        .ex_is_load       (ex_is_load),
        .ex_is_div        (ex_is_div),
        .mem_rd           (mem_rd),
        .mem_load_pending (mem_load_pending),
        .ex_br_mispredict (ex_br_mispredict),
        .ex_br_target     (ex_br_target),
        .wb_excp          (wb_excp),
        .wb_excp_target   (wb_excp_target),
        .redirect_ack     (redirect_ack),
        .ready_go         (ready_go),
        .flush            (flush),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc)
    );

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        stage_valid      = 5'b0;
        mem_allow_out    = 1'b1;
        id_rs1           = 5'd0;
        id_rs2           = 5'd0;
        id_rs1_use       = 1'b0;
        id_rs2_use       = 1'b0;
        ex_rd            = 5'd0;
        ex_wen           = 1'b0;
        ex_is_load       = 1'b0;
        ex_is_div        = 1'b0;
        mem_rd           = 5'd0;
        mem_load_pending = 1'b0;
        ex_br_mispredict = 1'b0;
        ex_br_target     = 32'h0;
        wb_excp          = 1'b0;
        wb_excp_target   = 32'h0;
        redirect_ack     = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        #1;
        n_checks++;
        if (ready_go !== 5'b11111) begin
            n_errors++; $display("FAIL reset_ready_go: got %b want 11111", ready_go);
        end
        n_checks++;
        if (flush !== 5'b00000) begin
            n_errors++; $display("FAIL reset_flush: got %b want 00000", flush);
        end
        n_checks++;
        if (redirect_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_redirect_valid: got %b want 0", redirect_valid);
        end
        n_checks++;
        if (redirect_pc !== 32'h0) begin
            n_errors++; $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        idle_inputs();
        stage_valid = 5'b00110; ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_rs1_use = 1'b1;
        #1;
        n_checks++;
        if (ready_go !== 5'b11101) begin
            n_errors++; $display("FAIL lu_ex_stall: got %b want 11101", ready_go);
        end
        n_checks++;
        if (flush !== 5'b0) begin
            n_errors++; $display("FAIL lu_no_flush: got %b want 00000", flush);
        end
        tick();
        // Load has moved to MEM with its data back: interlock released.
        stage_valid = 5'b01010; ex_is_load = 1'b0; mem_rd = 5'd5; mem_load_pending = 1'b0;
        #1;
        n_checks++;
        if (ready_go !== 5'b11111) begin
            n_errors++; $display("FAIL lu_release: got %b want 11111", ready_go);
        end
        tick();
        stage_valid = 5'b01010; mem_load_pending = 1'b1; mem_rd = 5'd7;
        id_rs1_use = 1'b0; id_rs2 = 5'd7; id_rs2_use = 1'b1;
        #1;
        n_checks++;
        if (ready_go !== 5'b11101) begin
            n_errors++; $display("FAIL lu_mem_pending: got %b want 11101", ready_go);
        end
        tick();
        idle_inputs();
        stage_valid = 5'b00110; ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd0;
        id_rs1 = 5'd0; id_rs1_use = 1'b1;
        #1;
        n_checks++;
        if (ready_go !== 5'b11111) begin
            n_errors++; $display("FAIL lu_r0: got %b want 11111", ready_go);
        end
        tick();
        ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_use = 1'b0;
        #1;
        n_checks++;
        if (ready_go !== 5'b11111) begin
            n_errors++; $display("FAIL lu_src_unused: got %b want 11111", ready_go);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_divide();
        idle_inputs();
        stage_valid = 5'b00100; ex_is_div = 1'b1; mem_allow_out = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (ready_go[2] !== (i == 3)) begin
                n_errors++;
                $display("FAIL div_cycle%0d: got %b want %b", i, ready_go[2], (i == 3));
            end
            tick();
        end
        idle_inputs();
        #1;
        n_checks++;
        if (ready_go !== 5'b11111) begin
            n_errors++; $display("FAIL div_after_handoff: got %b want 11111", ready_go);
        end
        tick();
        // Finished divide parked in EX while MEM refuses it for two cycles.
        stage_valid = 5'b00100; ex_is_div = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mem_allow_out = (i < 3) || (i == 5);
            #1;
            n_checks++;
            if (ready_go[2] !== (i >= 3) || flush !== 5'b0) begin
                n_errors++;
                $display("FAIL div_hold%0d: got rg2=%b flush=%b want rg2=%b flush=00000",
                         i, ready_go[2], flush, (i >= 3));
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_branch();
        idle_inputs();
        stage_valid = 5'b00100; ex_br_mispredict = 1'b1; ex_br_target = 32'h1c00_0100;
        #1;
        n_checks++;
        if (flush !== 5'b00011) begin
            n_errors++; $display("FAIL br_flush: got %b want 00011", flush);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (flush !== 5'b0 || redirect_valid !== 1'b1 || redirect_pc !== 32'h1c00_0100 ||
            ready_go !== 5'b11110) begin
            n_errors++;
            $display("FAIL br_redirect: got flush=%b rv=%b pc=%h rg=%b want 00000 1 1c000100 11110",
                     flush, redirect_valid, redirect_pc, ready_go);
        end
        tick();
        #1;
        n_checks++;
        if (redirect_valid !== 1'b1) begin
            n_errors++; $display("FAIL br_hold_until_ack: got %b want 1", redirect_valid);
        end
        tick();
        redirect_ack = 1'b1;
        #1;
        n_checks++;
        if (redirect_valid !== 1'b1 || ready_go[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL br_ack_cycle: got rv=%b rg0=%b want 1 0", redirect_valid, ready_go[0]);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (redirect_valid !== 1'b0 || ready_go !== 5'b11111) begin
            n_errors++;
            $display("FAIL br_exit: got rv=%b rg=%b want 0 11111", redirect_valid, ready_go);
        end
        tick();
    endtask

    task automatic test_excp_during_div();
        idle_inputs();
        stage_valid = 5'b00100; ex_is_div = 1'b1;
        tick();
        stage_valid = 5'b10100; wb_excp = 1'b1; wb_excp_target = 32'h1c00_8000;
        #1;
        n_checks++;
        if (flush !== 5'b11111) begin
            n_errors++; $display("FAIL excp_flush: got %b want 11111", flush);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1c00_8000 || ready_go !== 5'b11110) begin
            n_errors++;
            $display("FAIL excp_redirect: got rv=%b pc=%h rg=%b want 1 1c008000 11110",
                     redirect_valid, redirect_pc, ready_go);
        end
        tick();
        redirect_ack = 1'b1;
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (redirect_valid !== 1'b0 || ready_go !== 5'b11111) begin
            n_errors++;
            $display("FAIL excp_exit: got rv=%b rg=%b want 0 11111", redirect_valid, ready_go);
        end
        tick();
    endtask

    task automatic test_priority();
        idle_inputs();
        stage_valid = 5'b10100; wb_excp = 1'b1; wb_excp_target = 32'h1c00_0800;
        ex_br_mispredict = 1'b1; ex_br_target = 32'h1c00_0200;
        #1;
        n_checks++;
        if (flush !== 5'b11111) begin
            n_errors++; $display("FAIL prio_flush: got %b want 11111", flush);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (redirect_pc !== 32'h1c00_0800) begin
            n_errors++; $display("FAIL prio_pc: got %h want 1c000800", redirect_pc);
        end
        redirect_ack = 1'b1;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        stage_valid = 5'b00100; ex_br_mispredict = 1'b1; ex_br_target = 32'h1c00_0400;
        tick();
        idle_inputs();
        stage_valid = 5'b00100; ex_is_div = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (redirect_valid !== 1'b1 || ready_go[2] !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_setup: got rv=%b rg2=%b want 1 0", redirect_valid, ready_go[2]);
        end
        tick();
        reset = 1'b0;
        idle_inputs();
        #1;
        n_checks++;
        if (redirect_valid !== 1'b0 || ready_go !== 5'b11111 || flush !== 5'b0 ||
            redirect_pc !== 32'h0) begin
            n_errors++;
            $display("FAIL rstmid_outputs: got rv=%b rg=%b flush=%b pc=%h want 0 11111 00000 0",
                     redirect_valid, ready_go, flush, redirect_pc);
        end
        tick();
    endtask

    // Model state: divide age (-1 when no divide owns EX), redirect request and target.
    task automatic test_random(input int n_cycles);
        int          m_age;
        bit          m_redir;
        logic [31:0] m_pc;
        bit          e_excp, e_stall, e_lu, e_br, hit_ex, hit_mem;
        logic [4:0]  e_rg, e_flush;
        m_age   = -1;
        m_redir = 1'b0;
        m_pc    = 32'h0;
        for (int c = 0; c < n_cycles; c++) begin
            stage_valid      = 5'($urandom);
            mem_allow_out    = ($urandom_range(0, 2) != 0);
            id_rs1           = 5'($urandom_range(0, 3));
            id_rs2           = 5'($urandom_range(0, 3));
            id_rs1_use       = 1'($urandom);
            id_rs2_use       = 1'($urandom);
            ex_rd            = 5'($urandom_range(0, 3));
            ex_wen           = 1'($urandom);
            ex_is_load       = 1'($urandom);
            ex_is_div        = ($urandom_range(0, 5) == 0);
            mem_rd           = 5'($urandom_range(0, 3));
            mem_load_pending = 1'($urandom);
            ex_br_mispredict = ($urandom_range(0, 7) == 0);
            ex_br_target     = $urandom;
            wb_excp          = ($urandom_range(0, 15) == 0);
            wb_excp_target   = $urandom;
            redirect_ack     = ($urandom_range(0, 2) == 0);
            #1;
            e_excp = stage_valid[4] && wb_excp;
            if (m_age < 0) e_stall = stage_valid[2] && ex_is_div && (DivCycles > 1);
            else           e_stall = (m_age < int'(DivCycles) - 1);
            hit_ex  = stage_valid[2] && ex_is_load && ex_wen && ex_rd != 0 &&
                      ((id_rs1_use && id_rs1 == ex_rd) || (id_rs2_use && id_rs2 == ex_rd));
            hit_mem = stage_valid[3] && mem_load_pending && mem_rd != 0 &&
                      ((id_rs1_use && id_rs1 == mem_rd) || (id_rs2_use && id_rs2 == mem_rd));
            e_lu    = stage_valid[1] && (hit_ex || hit_mem);
            e_rg    = {1'b1, 1'b1, !e_stall, !e_lu, !m_redir};
            e_br    = stage_valid[2] && ex_br_mispredict && !e_stall && !e_excp;
            e_flush = e_excp ? 5'b11111 : (e_br ? 5'b00011 : 5'b00000);
            n_checks++;
            if (ready_go !== e_rg || flush !== e_flush || redirect_valid !== m_redir) begin
                n_errors++;
                $display("FAIL rand_c%0d: got rg=%b flush=%b rv=%b want rg=%b flush=%b rv=%b",
                         c, ready_go, flush, redirect_valid, e_rg, e_flush, m_redir);
            end
            if (m_redir) begin
                n_checks++;
                if (redirect_pc !== m_pc) begin
                    n_errors++;
                    $display("FAIL rand_pc_c%0d: got %h want %h", c, redirect_pc, m_pc);
                end
            end
            if (e_excp) begin
                m_age = -1;
            end else if (m_age < 0) begin
                if (stage_valid[2] && ex_is_div && DivCycles > 1) m_age = 1;
            end else if (m_age >= int'(DivCycles) - 1) begin
                if (mem_allow_out) m_age = -1;
            end else begin
                m_age++;
            end
            if (e_excp) begin
                m_redir = 1'b1; m_pc = wb_excp_target;
            end else if (e_br) begin
                m_redir = 1'b1; m_pc = ex_br_target;
            end else if (m_redir && redirect_ack) begin
                m_redir = 1'b0;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_divide();
        test_branch();
        test_excp_during_div();
        test_priority();
        test_reset_mid();
        test_random(400);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
